// File: rtl/demux_pkg.sv
// demux_pkg: shared parameter defaults and slot-state encoding for demux1to2_stage.
// The skid-buffer slot variant (macro DEMUX_SKID_EN) uses EMPTY/ONE/TWO, the plain slot uses EMPTY/FULL.
package demux_pkg;

    localparam int DEMUX_WIDTH_DEF = 32;
    localparam int DEMUX_CNT_W_DEF = 16;

    typedef enum logic [1:0] {
        EMPTY = 2'd0,
        ONE   = 2'd1,
        TWO   = 2'd2,
        FULL  = 2'd3
    } slot_state_e;

    function automatic logic slot_has_word(input slot_state_e st);
        return st != EMPTY;
    endfunction

endpackage

// File: rtl/demux_slot.sv
// demux_slot: per-port output buffer of the 1-to-2 demux, one or two entries deep.
// DEMUX_SKID_EN defined: two-entry skid slot with registered wr_ready; undefined: single entry.
//
// state | meaning
// EMPTY | no word held, rd_valid low
// ONE   | head entry holds a word (skid build)
// TWO   | head and skid entries both hold words, wr_ready low (skid build)
// FULL  | single entry holds a word (plain build)
module demux_slot
    import demux_pkg::*;
#(
    parameter int WIDTH = DEMUX_WIDTH_DEF
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             flush,
    input  logic             wr_en,
    input  logic [WIDTH-1:0] wr_data,
    output logic             wr_ready,
    output logic             rd_valid,
    output logic [WIDTH-1:0] rd_data,
    input  logic             rd_ready
);

    slot_state_e      state_q, state_d;
    logic [WIDTH-1:0] head_q, head_d;
    logic             valid_q, valid_d;
    logic             rd_fire;

    assign rd_fire  = valid_q & rd_ready;
    assign rd_valid = valid_q;
    assign rd_data  = head_q;

`ifdef DEMUX_SKID_EN

    logic [WIDTH-1:0] skid_q, skid_d;
    logic             ready_q, ready_d;

    always_comb begin
        state_d = state_q;
        head_d  = head_q;
        skid_d  = skid_q;
        unique case (state_q)
            EMPTY: begin
                if (wr_en) begin
                    head_d  = wr_data;
                    state_d = ONE;
                end
            end
            ONE: begin
                if (wr_en && rd_fire) begin
                    head_d = wr_data;
                end else if (wr_en) begin
                    skid_d  = wr_data;
                    state_d = TWO;
                end else if (rd_fire) begin
                    state_d = EMPTY;
                end
            end
            TWO: begin
                // wr_ready is low here, so only a drain can move the slot
                if (rd_fire) begin
                    head_d  = skid_q;
                    state_d = ONE;
                end
            end
            default: state_d = EMPTY;
        endcase
        if (flush) begin
            state_d = EMPTY;
        end
        valid_d = slot_has_word(state_d);
        ready_d = (state_d != TWO);
    end

    // ready_q resets high; the top level masks in_ready while rst is asserted
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= EMPTY;
            head_q  <= '0;
            skid_q  <= '0;
            valid_q <= 1'b0;
            ready_q <= 1'b1;
        end else begin
            state_q <= state_d;
            head_q  <= head_d;
            skid_q  <= skid_d;
            valid_q <= valid_d;
            ready_q <= ready_d;
        end
    end

    assign wr_ready = ready_q;

`else

    always_comb begin
        state_d = state_q;
        head_d  = head_q;
        unique case (state_q)
            EMPTY: begin
                if (wr_en) begin
                    head_d  = wr_data;
                    state_d = FULL;
                end
            end
            FULL: begin
                // a write into FULL is only offered alongside a drain
                if (wr_en) begin
                    head_d = wr_data;
                end else if (rd_fire) begin
                    state_d = EMPTY;
                end
            end
            default: state_d = EMPTY;
        endcase
        if (flush) begin
            state_d = EMPTY;
        end
        valid_d = slot_has_word(state_d);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= EMPTY;
            head_q  <= '0;
            valid_q <= 1'b0;
        end else begin
            state_q <= state_d;
            head_q  <= head_d;
            valid_q <= valid_d;
        end
    end

    assign wr_ready = ~valid_q | rd_ready;

`endif

endmodule

// File: rtl/demux1to2_stage.sv
// demux1to2_stage: routes each accepted word to out0 or out1 by in_sel, with per-port transfer counters.
// Build option DEMUX_SKID_EN selects two-entry skid slots with a registered in_ready.
module demux1to2_stage
    import demux_pkg::*;
#(
    parameter int WIDTH = DEMUX_WIDTH_DEF,
    parameter int CNT_W = DEMUX_CNT_W_DEF
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [WIDTH-1:0] in_data,
    input  logic             in_sel,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic             flush,
    output logic [WIDTH-1:0] out0_data,
    output logic             out0_valid,
    input  logic             out0_ready,
    output logic [WIDTH-1:0] out1_data,
    output logic             out1_valid,
    input  logic             out1_ready,
    output logic [CNT_W-1:0] cnt0,
    output logic [CNT_W-1:0] cnt1
);

    logic             slot0_wr_ready;
    logic             slot1_wr_ready;
    logic             sel_ready;
    logic             accept;
    logic             wr0;
    logic             wr1;
    logic             xfer0;
    logic             xfer1;
    logic [CNT_W-1:0] cnt0_q, cnt0_d;
    logic [CNT_W-1:0] cnt1_q, cnt1_d;

    // in_ready looks only at the selected slot so a stalled other port never blocks
    always_comb begin
        sel_ready = in_sel ? slot1_wr_ready : slot0_wr_ready;
        in_ready  = sel_ready & ~rst & ~flush;
        accept    = in_valid & in_ready;
        wr0       = accept & ~in_sel;
        wr1       = accept & in_sel;
        xfer0     = out0_valid & out0_ready & ~flush;
        xfer1     = out1_valid & out1_ready & ~flush;
        cnt0_d    = cnt0_q + {{(CNT_W-1){1'b0}}, xfer0};
        cnt1_d    = cnt1_q + {{(CNT_W-1){1'b0}}, xfer1};
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            cnt0_q <= '0;
            cnt1_q <= '0;
        end else begin
            cnt0_q <= cnt0_d;
            cnt1_q <= cnt1_d;
        end
    end

    assign cnt0 = cnt0_q;
    assign cnt1 = cnt1_q;

    demux_slot #(
        .WIDTH (WIDTH)
    ) u_slot0 (
        .clk      (clk),
        .rst      (rst),
        .flush    (flush),
        .wr_en    (wr0),
        .wr_data  (in_data),
        .wr_ready (slot0_wr_ready),
        .rd_valid (out0_valid),
        .rd_data  (out0_data),
        .rd_ready (out0_ready)
    );

    demux_slot #(
        .WIDTH (WIDTH)
    ) u_slot1 (
        .clk      (clk),
        .rst      (rst),
        .flush    (flush),
        .wr_en    (wr1),
        .wr_data  (in_data),
        .wr_ready (slot1_wr_ready),
        .rd_valid (out1_valid),
        .rd_data  (out1_data),
        .rd_ready (out1_ready)
    );

endmodule

// File: tb/tb_demux1to2_stage.sv
// tb_demux1to2_stage: directed scenarios plus a random run, checked against a per-port queue model.
// Expected in_ready follows the build: DEMUX_SKID_EN defined uses slot occupancy only.
module tb_demux1to2_stage;

    localparam int WIDTH   = 32;
    localparam int CNT_W   = 4;
    localparam int CNT_MOD = 1 << CNT_W;
`ifdef DEMUX_SKID_EN
    localparam bit SKID = 1'b1;
`else
    localparam bit SKID = 1'b0;
`endif

    logic             clk = 1'b0;
    logic             rst = 1'b1;
    logic [WIDTH-1:0] in_data = '0;
    logic             in_sel = 1'b0;
    logic             in_valid = 1'b0;
    logic             in_ready;
    logic             flush = 1'b0;
    logic [WIDTH-1:0] out0_data;
    logic             out0_valid;
    logic             out0_ready = 1'b0;
    logic [WIDTH-1:0] out1_data;
    logic             out1_valid;
    logic             out1_ready = 1'b0;
    logic [CNT_W-1:0] cnt0;
    logic [CNT_W-1:0] cnt1;

    int               checks = 0;
    int               errors = 0;
    logic [WIDTH-1:0] q0[$];
    logic [WIDTH-1:0] q1[$];
    int               exp_cnt0 = 0;
    int               exp_cnt1 = 0;

    demux1to2_stage #(
        .WIDTH (WIDTH),
        .CNT_W (CNT_W)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .in_data    (in_data),
        .in_sel     (in_sel),
        .in_valid   (in_valid),
        .in_ready   (in_ready),
        .flush      (flush),
        .out0_data  (out0_data),
        .out0_valid (out0_valid),
        .out0_ready (out0_ready),
        .out1_data  (out1_data),
        .out1_valid (out1_valid),
        .out1_ready (out1_ready),
        .cnt0       (cnt0),
        .cnt1       (cnt1)
    );

    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    // Scoreboard: inputs change 1ns after posedge, so at negedge both inputs and outputs are
    // settled for the coming edge. Compare, then advance the model across that edge.
    always @(negedge clk) begin : scoreboard
        int               occ;
        logic             exp_rdy;
        logic [CNT_W-1:0] ec0;
        logic [CNT_W-1:0] ec1;
        if (rst) begin
            checks++;
            if (in_ready !== 1'b0) begin
                errors++;
                $display("FAIL sb_in_ready_rst: got %b want 0", in_ready);
            end
            q0.delete();
            q1.delete();
            exp_cnt0 = 0;
            exp_cnt1 = 0;
        end else begin
            occ = in_sel ? q1.size() : q0.size();
            if (flush) exp_rdy = 1'b0;
            else if (SKID) exp_rdy = (occ != 2);
            else exp_rdy = (occ == 0) || (in_sel ? out1_ready : out0_ready);
            ec0 = exp_cnt0[CNT_W-1:0];
            ec1 = exp_cnt1[CNT_W-1:0];

            checks++;
            if (in_ready !== exp_rdy) begin
                errors++;
                $display("FAIL sb_in_ready: got %b want %b (sel=%b t=%0t)", in_ready, exp_rdy, in_sel, $time);
            end
            checks++;
            if (out0_valid !== (q0.size() != 0)) begin
                errors++;
                $display("FAIL sb_out0_valid: got %b want %b t=%0t", out0_valid, (q0.size() != 0), $time);
            end else if (q0.size() != 0) begin
                checks++;
                if (out0_data !== q0[0]) begin
                    errors++;
                    $display("FAIL sb_out0_data: got %h want %h t=%0t", out0_data, q0[0], $time);
                end
            end
            checks++;
            if (out1_valid !== (q1.size() != 0)) begin
                errors++;
                $display("FAIL sb_out1_valid: got %b want %b t=%0t", out1_valid, (q1.size() != 0), $time);
            end else if (q1.size() != 0) begin
                checks++;
                if (out1_data !== q1[0]) begin
                    errors++;
                    $display("FAIL sb_out1_data: got %h want %h t=%0t", out1_data, q1[0], $time);
                end
            end
            checks++;
            if (cnt0 !== ec0 || cnt1 !== ec1) begin
                errors++;
                $display("FAIL sb_counters: got cnt0=%0d cnt1=%0d want %0d %0d t=%0t", cnt0, cnt1, ec0, ec1, $time);
            end

            if (flush) begin
                q0.delete();
                q1.delete();
            end else begin
                if (q0.size() != 0 && out0_ready) begin
                    void'(q0.pop_front());
                    exp_cnt0 = (exp_cnt0 + 1) % CNT_MOD;
                end
                if (q1.size() != 0 && out1_ready) begin
                    void'(q1.pop_front());
                    exp_cnt1 = (exp_cnt1 + 1) % CNT_MOD;
                end
                if (in_valid && exp_rdy) begin
                    if (in_sel) q1.push_back(in_data);
                    else q0.push_back(in_data);
                end
            end
        end
    end

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        repeat (3) cyc();
        in_valid = 1'b1;
        in_sel   = 1'b0;
        #1;
        checks++;
        if (in_ready !== 1'b0) begin errors++; $display("FAIL reset_in_ready: got %b want 0", in_ready); end
        checks++;
        if (out0_valid !== 1'b0 || out1_valid !== 1'b0) begin
            errors++; $display("FAIL reset_valids: got %b %b want 0 0", out0_valid, out1_valid);
        end
        checks++;
        if (out0_data !== '0 || out1_data !== '0) begin
            errors++; $display("FAIL reset_data: got %h %h want 0 0", out0_data, out1_data);
        end
        checks++;
        if (cnt0 !== '0 || cnt1 !== '0) begin
            errors++; $display("FAIL reset_counters: got %0d %0d want 0 0", cnt0, cnt1);
        end
        in_valid = 1'b0;
        rst      = 1'b0;
    endtask

    task automatic test_basic_routing();
        out0_ready = 1'b1;
        out1_ready = 1'b1;
        cyc();
        in_valid = 1'b1; in_sel = 1'b0; in_data = 32'hDEADBEEF;
        cyc();
        checks++;
        if (out0_valid !== 1'b1 || out0_data !== 32'hDEADBEEF || out1_valid !== 1'b0) begin
            errors++; $display("FAIL basic_port0: got v0=%b d0=%h v1=%b want 1 deadbeef 0", out0_valid, out0_data, out1_valid);
        end
        in_sel = 1'b1; in_data = 32'h12345678;
        cyc();
        in_valid = 1'b0;
        checks++;
        if (out1_valid !== 1'b1 || out1_data !== 32'h12345678 || out0_valid !== 1'b0) begin
            errors++; $display("FAIL basic_port1: got v1=%b d1=%h v0=%b want 1 12345678 0", out1_valid, out1_data, out0_valid);
        end
        cyc();
        checks++;
        if (cnt0 !== 4'd1 || cnt1 !== 4'd1) begin
            errors++; $display("FAIL basic_counters: got %0d %0d want 1 1", cnt0, cnt1);
        end
    endtask

    task automatic test_backpressure();
        logic [WIDTH-1:0] words[3];
        logic             exp_rdy;
        words[0] = 32'hB0B0_0001;
        words[1] = 32'hB0B0_0002;
        words[2] = 32'hB0B0_0003;
        out0_ready = 1'b0;
        out1_ready = 1'b1;
        for (int i = 0; i < 3; i++) begin
            cyc();
            in_valid = 1'b1; in_sel = 1'b0; in_data = words[i];
            @(negedge clk);
            exp_rdy = (i == 0) || (SKID && i == 1);
            checks++;
            if (in_ready !== exp_rdy) begin
                errors++; $display("FAIL bp_in_ready_%0d: got %b want %b", i, in_ready, exp_rdy);
            end
        end
        cyc();
        in_sel = 1'b1; in_data = 32'hA5A5_0001;
        checks++;
        if (out0_valid !== 1'b1 || out0_data !== words[0]) begin
            errors++; $display("FAIL bp_hold: got v=%b d=%h want 1 %h", out0_valid, out0_data, words[0]);
        end
        @(negedge clk);
        checks++;
        if (in_ready !== 1'b1) begin errors++; $display("FAIL bp_port1_ready: got %b want 1", in_ready); end
        cyc();
        in_valid = 1'b0;
        checks++;
        if (out1_valid !== 1'b1 || out1_data !== 32'hA5A5_0001 || out0_data !== words[0]) begin
            errors++; $display("FAIL bp_port1_flow: got v1=%b d1=%h d0=%h", out1_valid, out1_data, out0_data);
        end
        out0_ready = 1'b1;
        repeat (3) cyc();
        checks++;
        if (out0_valid !== 1'b0) begin errors++; $display("FAIL bp_drain: got %b want 0", out0_valid); end
    endtask

    task automatic test_independence();
        int               c1_start;
        logic [CNT_W-1:0] exp_c1;
        out0_ready = 1'b0;
        out1_ready = 1'b1;
        for (int i = 0; i < (SKID ? 2 : 1); i++) begin
            cyc();
            in_valid = 1'b1; in_sel = 1'b0; in_data = 32'h0F0F_0000 + i;
        end
        cyc();
        in_valid = 1'b0;
        c1_start = exp_cnt1;
        for (int i = 0; i < 8; i++) begin
            cyc();
            in_valid = 1'b1; in_sel = 1'b1; in_data = 32'h1000 + i;
            @(negedge clk);
            checks++;
            if (in_ready !== 1'b1) begin errors++; $display("FAIL indep_ready_%0d: got %b want 1", i, in_ready); end
            if (i > 0) begin
                checks++;
                if (out1_valid !== 1'b1) begin errors++; $display("FAIL indep_stream_%0d: got %b want 1", i, out1_valid); end
            end
        end
        cyc();
        in_valid = 1'b0;
        cyc();
        exp_c1 = CNT_W'((c1_start + 8) % CNT_MOD);
        checks++;
        if (cnt1 !== exp_c1 || out0_valid !== 1'b1) begin
            errors++; $display("FAIL indep_result: got cnt1=%0d v0=%b want %0d 1", cnt1, out0_valid, exp_c1);
        end
        out0_ready = 1'b1;
        repeat (3) cyc();
    endtask

    task automatic test_flush();
        logic [CNT_W-1:0] c0;
        logic [CNT_W-1:0] c1;
        out0_ready = 1'b0;
        out1_ready = 1'b0;
        cyc();
        in_valid = 1'b1; in_sel = 1'b0; in_data = 32'hF1F1_0000;
        cyc();
        in_sel = 1'b1; in_data = 32'hF1F1_0001;
        cyc();
        c0 = exp_cnt0[CNT_W-1:0];
        c1 = exp_cnt1[CNT_W-1:0];
        flush = 1'b1;
        in_sel = 1'b0; in_data = 32'hBAD0_BAD0;
        out0_ready = 1'b1;
        out1_ready = 1'b1;
        @(negedge clk);
        checks++;
        if (in_ready !== 1'b0 || out0_valid !== 1'b1 || out1_valid !== 1'b1) begin
            errors++; $display("FAIL flush_pre: got rdy=%b v0=%b v1=%b want 0 1 1", in_ready, out0_valid, out1_valid);
        end
        cyc();
        flush = 1'b0;
        in_valid = 1'b0;
        checks++;
        if (out0_valid !== 1'b0 || out1_valid !== 1'b0) begin
            errors++; $display("FAIL flush_valids: got %b %b want 0 0", out0_valid, out1_valid);
        end
        checks++;
        if (cnt0 !== c0 || cnt1 !== c1) begin
            errors++; $display("FAIL flush_counters: got %0d %0d want %0d %0d", cnt0, cnt1, c0, c1);
        end
        cyc();
        checks++;
        if (out0_valid !== 1'b0) begin errors++; $display("FAIL flush_not_accepted: got %b want 0", out0_valid); end
    endtask

    task automatic test_counter_wrap();
        rst = 1'b1;
        cyc();
        rst = 1'b0;
        out0_ready = 1'b1;
        out1_ready = 1'b1;
        for (int i = 0; i < 17; i++) begin
            cyc();
            in_valid = 1'b1; in_sel = 1'b1; in_data = $urandom;
        end
        cyc();
        in_valid = 1'b0;
        cyc();
        checks++;
        if (cnt1 !== 4'd1 || cnt0 !== 4'd0) begin
            errors++; $display("FAIL wrap_counters: got cnt1=%0d cnt0=%0d want 1 0", cnt1, cnt0);
        end
    endtask

    task automatic test_reset_midstream();
        out0_ready = 1'b1;
        out1_ready = 1'b1;
        for (int i = 0; i < 6; i++) begin
            cyc();
            in_valid = 1'b1; in_sel = i[0]; in_data = 32'h5000 + i;
        end
        cyc();
        rst = 1'b1;
        in_data = 32'h5555_AAAA;
        cyc();
        rst = 1'b0;
        in_valid = 1'b0;
        checks++;
        if (out0_valid !== 1'b0 || out1_valid !== 1'b0 || out0_data !== '0 || out1_data !== '0) begin
            errors++; $display("FAIL midrst_outputs: got v=%b%b d0=%h d1=%h want all 0", out0_valid, out1_valid, out0_data, out1_data);
        end
        checks++;
        if (cnt0 !== '0 || cnt1 !== '0) begin
            errors++; $display("FAIL midrst_counters: got %0d %0d want 0 0", cnt0, cnt1);
        end
        cyc();
        in_valid = 1'b1; in_sel = 1'b1; in_data = 32'hCAFEF00D;
        cyc();
        in_valid = 1'b0;
        checks++;
        if (out1_valid !== 1'b1 || out1_data !== 32'hCAFEF00D || out0_valid !== 1'b0) begin
            errors++; $display("FAIL midrst_first_word: got v1=%b d1=%h v0=%b", out1_valid, out1_data, out0_valid);
        end
        cyc();
        checks++;
        if (cnt1 !== 4'd1) begin errors++; $display("FAIL midrst_cnt1: got %0d want 1", cnt1); end
    endtask

    task automatic test_back_to_back();
        bit drained;
        for (int i = 0; i < 300; i++) begin
            cyc();
            in_valid   = ($urandom_range(0, 3) != 0);
            in_sel     = ($urandom_range(0, 1) == 1);
            in_data    = $urandom;
            out0_ready = ($urandom_range(0, 3) != 0);
            out1_ready = ($urandom_range(0, 3) != 0);
            flush      = ($urandom_range(0, 49) == 0);
        end
        cyc();
        in_valid   = 1'b0;
        flush      = 1'b0;
        out0_ready = 1'b1;
        out1_ready = 1'b1;
        drained = 1'b0;
        for (int i = 0; i < 50 && !drained; i++) begin
            cyc();
            drained = (q0.size() == 0) && (q1.size() == 0);
        end
        checks++;
        if (!drained || out0_valid !== 1'b0 || out1_valid !== 1'b0) begin
            errors++; $display("FAIL b2b_drain: model left %0d/%0d words, valids %b %b", q0.size(), q1.size(), out0_valid, out1_valid);
        end
    endtask

    initial begin
        test_reset();
        test_basic_routing();
        test_backpressure();
        test_independence();
        test_flush();
        test_counter_wrap();
        test_reset_midstream();
        test_back_to_back();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
